// File: rtl/seq_pattern_gen_pkg.sv
// ============================================================================
// Module : seq_pattern_gen_pkg
// Brief  : Shared state encodings, line level and length helper for the
//          serial pattern generator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_pattern_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic IDLE_LEVEL    = 1'b0;
  localparam int   PAT_W_DEFAULT = 8;

  // A programmed length of 0 or beyond the register width means a full frame.
  function automatic int eff_len(input int len, input int pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_reg.sv
// ============================================================================
// Module : seq_shift_reg
// Brief  : Loadable left-shift register with bit count-down, first/last flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_shift_reg
  import seq_pattern_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             msb_o,
  output logic             first_o,
  output logic             last_o
);

  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  // len_i is already clamped to 1..PAT_W, so the left-align shift never overflows.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (load_i) begin
      shreg_d = pattern_i << (LEN_W'(PAT_W) - len_i);
      cnt_d   = len_i;
      first_d = 1'b1;
    end else if (shift_i) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - LEN_W'(1);
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign msb_o   = shreg_q[PAT_W-1];
  assign first_o = first_q;
  assign last_o  = (cnt_q == LEN_W'(1));

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module : seq_pattern_gen
// Brief  : Bit-serial pattern transmitter with frame repeat and zero gaps.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_tick,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] n_frames,
  input  logic [GAP_W-1:0] gap,
  output logic             seq_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
  logic             seq_out_q, seq_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sr_load, sr_shift;
  logic             sr_msb, sr_first, sr_last;
  logic [LEN_W-1:0] len_eff;
  logic [PAT_W-1:0] ld_pat;
  logic [LEN_W-1:0] ld_len;

  assign len_eff = LEN_W'(eff_len(int'(len), PAT_W));

  // At acceptance the register loads straight from the ports; later reloads use the latched copy.
  assign ld_pat = (state_q == ST_IDLE) ? pattern : pat_q;
  assign ld_len = (state_q == ST_IDLE) ? len_eff : len_q;

  seq_shift_reg #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (sr_load),
    .shift_i   (sr_shift),
    .pattern_i (ld_pat),
    .len_i     (ld_len),
    .msb_o     (sr_msb),
    .first_o   (sr_first),
    .last_o    (sr_last)
  );

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    len_d         = len_q;
    frames_d      = frames_q;
    gap_d         = gap_q;
    gapcnt_d      = gapcnt_q;
    seq_out_d     = seq_out_q;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      seq_out_d = IDLE_LEVEL;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // done_q high means we are in the completion cycle; a start there is dropped.
          if (start && !done_q) begin
            pat_d    = pattern;
            len_d    = len_eff;
            frames_d = (n_frames == '0) ? CNT_W'(1) : n_frames;
            gap_d    = gap;
            sr_load  = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_SEND;
          end
        end

        ST_SEND: begin
          if (en_tick) begin
            seq_out_d     = sr_msb;
            bit_valid_d   = 1'b1;
            frame_start_d = sr_first;
            sr_shift      = 1'b1;
            if (sr_last) begin
              if (frames_q > CNT_W'(1)) begin
                frames_d = frames_q - CNT_W'(1);
                if (gap_q != '0) begin
                  gapcnt_d = gap_q;
                  state_d  = ST_GAP;
                end else begin
                  sr_load = 1'b1;
                end
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end

        ST_GAP: begin
          if (en_tick) begin
            seq_out_d   = IDLE_LEVEL;
            bit_valid_d = 1'b1;
            gapcnt_d    = gapcnt_q - GAP_W'(1);
            if (gapcnt_q == GAP_W'(1)) begin
              sr_load = 1'b1;
              state_d = ST_SEND;
            end
          end
        end

        ST_DONE: begin
          seq_out_d = IDLE_LEVEL;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pat_q         <= '0;
      len_q         <= '0;
      frames_q      <= '0;
      gap_q         <= '0;
      gapcnt_q      <= '0;
      seq_out_q     <= IDLE_LEVEL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      len_q         <= len_d;
      frames_q      <= frames_d;
      gap_q         <= gap_d;
      gapcnt_q      <= gapcnt_d;
      seq_out_q     <= seq_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign seq_out     = seq_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

`default_nettype wire
